// File: rtl/l_class_oc_heard_arb.sv
// Round-robin arbiter sharing one downstream heard channel among 4 requesters,
// with a one-entry output buffer. Define L_CLASS_OC_HEARD_ARB_STATS_EN for per-requester grant counters.
module l_class_oc_heard_arb (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [3:0]   req_heard_ena,
    input  logic [127:0] req_meth,
    input  logic [127:0] req_v,
    output logic [3:0]   req_heard_rdy,
    output logic         indication_heard_ena,
    input  logic         indication_heard_rdy,
    output logic [31:0]  indication_meth,
    output logic [31:0]  indication_v
`ifdef L_CLASS_OC_HEARD_ARB_STATS_EN
    ,
    output logic [63:0]  grant_count
`endif
);

    logic        full;
    logic [31:0] meth_reg;
    logic [31:0] v_reg;
    logic [1:0]  ptr;

    logic        free;
    logic        pop;
    logic        accept;
    logic        found;
    logic [1:0]  winner;
    logic [1:0]  idx;

    assign free = !full || indication_heard_rdy;
    assign pop  = full && indication_heard_rdy;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Reset is folded in so no requester sees a grant while reset is held.
    always_comb begin
        req_heard_rdy = '0;
        if (!rst && free && found)
            req_heard_rdy[winner] = 1'b1;
    end

    assign accept = |(req_heard_ena & req_heard_rdy);

    assign indication_heard_ena = pop;
    assign indication_meth      = full ? meth_reg : 32'd0;
    assign indication_v         = full ? v_reg    : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            meth_reg <= '0;
            v_reg    <= '0;
            ptr      <= '0;
        end else if (accept) begin
            full     <= 1'b1;
            meth_reg <= req_meth[{winner, 5'd0} +: 32];
            v_reg    <= req_v[{winner, 5'd0} +: 32];
            ptr      <= winner + 2'd1;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end

`ifdef L_CLASS_OC_HEARD_ARB_STATS_EN
    logic [15:0] cnt [4];

    // Counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
        end else if (accept && cnt[winner] != 16'hFFFF) begin
            cnt[winner] <= cnt[winner] + 16'd1;
        end
    end

    assign grant_count = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_l_class_oc_heard_arb.sv
// Self-checking bench for l_class_oc_heard_arb: a directed vector table plus
// hand-written multi-cycle sequences (fairness, stall, reset mid-transfer).
module tb_l_class_oc_heard_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_heard_ena;
    logic [127:0] req_meth;
    logic [127:0] req_v;
    logic [3:0]   req_heard_rdy;
    logic         indication_heard_ena;
    logic         indication_heard_rdy;
    logic [31:0]  indication_meth;
    logic [31:0]  indication_v;
`ifdef L_CLASS_OC_HEARD_ARB_STATS_EN
    logic [63:0]  grant_count;
`endif

    int checks   = 0;
    int failures = 0;

    l_class_oc_heard_arb dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_heard_ena        (req_heard_ena),
        .req_meth             (req_meth),
        .req_v                (req_v),
        .req_heard_rdy        (req_heard_rdy),
        .indication_heard_ena (indication_heard_ena),
        .indication_heard_rdy (indication_heard_rdy),
        .indication_meth      (indication_meth),
        .indication_v         (indication_v)
`ifdef L_CLASS_OC_HEARD_ARB_STATS_EN
        ,
        .grant_count          (grant_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  ena;
        logic        rdy;
        logic [3:0]  exp_rdy;
        logic        exp_ena;
        logic [31:0] exp_meth;
        logic [31:0] exp_v;
    } vec_t;

    vec_t vecs [17];

    task automatic setData(input logic [31:0] mbase, input logic [31:0] vbase);
        for (int i = 0; i < 4; i++) begin
            req_meth[32*i +: 32] = mbase + 32'(i);
            req_v[32*i +: 32]    = vbase + 32'(i);
        end
    endtask

    // Drive inputs just after the falling edge, leave 1 time unit to settle.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] ena, input logic rdy);
        @(negedge clk);
        req_valid            = valid;
        req_heard_ena        = ena;
        indication_heard_rdy = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_rdy, input logic exp_ena,
                               input logic [31:0] exp_meth, input logic [31:0] exp_v);
        checks++;
        if (req_heard_rdy !== exp_rdy || indication_heard_ena !== exp_ena ||
            (exp_ena && (indication_meth !== exp_meth || indication_v !== exp_v))) begin
            failures++;
            $display("[TB] FAIL %s: got rdy=%b ena=%b meth=%0d v=%0d, want rdy=%b ena=%b meth=%0d v=%0d",
                     name, req_heard_rdy, indication_heard_ena, indication_meth, indication_v,
                     exp_rdy, exp_ena, exp_meth, exp_v);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst                  = 1'b1;
        req_valid            = 4'b1111;
        req_heard_ena        = 4'b1111;
        indication_heard_rdy = 1'b1;
        #1;
        checks++;
        if (req_heard_rdy !== 4'b0 || indication_heard_ena !== 1'b0 ||
            indication_meth !== 32'd0 || indication_v !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got rdy=%b ena=%b meth=%0d v=%0d, want all zero",
                     req_heard_rdy, indication_heard_ena, indication_meth, indication_v);
        end
        @(negedge clk);
        rst           = 1'b0;
        req_valid     = 4'b0;
        req_heard_ena = 4'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        req_valid            = '0;
        req_heard_ena        = '0;
        indication_heard_rdy = 1'b0;
        setData(32'd100, 32'd200);

        vecs[0]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 32'd0,   32'd0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'd101, 32'd201};
        vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, 32'd0,   32'd0};
        vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'd102, 32'd202};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'd103, 32'd203};
        vecs[5]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'd0,   32'd0};
        vecs[6]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 32'd0,   32'd0};
        vecs[7]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 32'd100, 32'd200};
        vecs[8]  = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, 32'd0,   32'd0};
        vecs[9]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, 32'd0,   32'd0};
        vecs[10] = '{4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 32'd0,   32'd0};
        vecs[11] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'd100, 32'd200};
        vecs[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'd101, 32'd201};
        vecs[13] = '{4'b1000, 4'b0100, 1'b1, 4'b1000, 1'b0, 32'd0,   32'd0};
        vecs[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'd0,   32'd0};
        vecs[15] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0, 32'd0,   32'd0};
        vecs[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'd102, 32'd202};

        // Directed table.
        doReset();
        for (int n = 0; n < 17; n++) begin
            applyStimulus(vecs[n].valid, vecs[n].ena, vecs[n].rdy);
            checkOutput($sformatf("vec%0d", n), vecs[n].exp_rdy, vecs[n].exp_ena,
                        vecs[n].exp_meth, vecs[n].exp_v);
        end

        // Single transfer with meth=5, v=7 from requester 1; ptr then points at 2.
        doReset();
        req_meth[63:32] = 32'd5;
        req_v[63:32]    = 32'd7;
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        checkOutput("single_grant", 4'b0010, 1'b0, 32'd0, 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("single_deliver", 4'b0000, 1'b1, 32'd5, 32'd7);
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        checkOutput("single_ptr2", 4'b0100, 1'b0, 32'd0, 32'd0);

        // Fairness: all valid, continuous ENA, downstream always ready.
        doReset();
        setData(32'd100, 32'd200);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b1);
            checkOutput($sformatf("fair%0d", k), 4'(1 << (k % 4)), k > 0,
                        32'd100 + 32'((k + 3) % 4), 32'd200 + 32'((k + 3) % 4));
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("fair_tail", 4'b0000, 1'b1, 32'd103, 32'd203);

        // Stall: buffer full with downstream not ready for 5 cycles.
        doReset();
        applyStimulus(4'b0001, 4'b0001, 1'b0);
        checkOutput("stall_fill", 4'b0001, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b0);
            checkOutput($sformatf("stall%0d", k), 4'b0000, 1'b0, 32'd0, 32'd0);
            checks++;
            if (indication_meth !== 32'd100 || indication_v !== 32'd200) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: got meth=%0d v=%0d, want meth=100 v=200",
                         k, indication_meth, indication_v);
            end
        end
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        checkOutput("stall_release", 4'b0010, 1'b1, 32'd100, 32'd200);

        // Reset asserted mid-transfer with meth=9 buffered.
        doReset();
        req_meth[63:32] = 32'd9;
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (indication_meth !== 32'd9) begin
            failures++;
            $display("[TB] FAIL midreset_loaded: got meth=%0d, want 9", indication_meth);
        end
        #2;
        rst                  = 1'b1;
        indication_heard_rdy = 1'b1;
        #1;
        checks++;
        if (indication_meth !== 32'd0 || indication_v !== 32'd0 || indication_heard_ena !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_clear: got meth=%0d v=%0d ena=%b, want 0 0 0",
                     indication_meth, indication_v, indication_heard_ena);
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("midreset_no_ena", 4'b0000, 1'b0, 32'd0, 32'd0);
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        checkOutput("midreset_ptr0", 4'b0001, 1'b0, 32'd0, 32'd0);

`ifdef L_CLASS_OC_HEARD_ARB_STATS_EN
        // Saturation of requester 2's counter.
        doReset();
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        repeat (69999) @(negedge clk);
        req_valid     = 4'b0;
        req_heard_ena = 4'b0;
        #1;
        checks++;
        if (grant_count !== 64'h0000_FFFF_0000_0000) begin
            failures++;
            $display("[TB] FAIL stats_sat: got %h, want 0000ffff00000000", grant_count);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l_class_oc_heard_arb.md
L_CLASS_OC_HEARD_ARB -- requirements
Module: l_class_OC_heard_arb

Interface
REQ-001 CLK  input  1  rising-edge clock for all state.
REQ-002 nRST  input  1  reset, asynchronous, active-high (asserted = 1 despite name).
REQ-003 req$valid  input  4  per-requester intent to send heard(meth,v); level, independent of RDY.
REQ-004 req$heard__ENA  input  4  per-requester enable; honoured only when matching req$heard__RDY bit = 1.
REQ-005 req$meth  input  128  four 32-bit meth fields, requester i in bits [32i+31:32i].
REQ-006 req$v  input  128  four 32-bit v fields, same packing.
REQ-007 req$heard__RDY  output  4  one-hot or zero grant/ready to requesters.
REQ-008 indication$heard__ENA  output  1  downstream enable carrying buffered message.
REQ-009 indication$heard__RDY  input  1  downstream ready.
REQ-010 indication$meth  output  32  buffered meth.
REQ-011 indication$v  output  32  buffered v.
REQ-012 grant_count  output  64  four 16-bit grant counters, requester i in [16i+15:16i]; present only with REQ-030 macro.

Function
REQ-013 Shares one downstream indication$heard channel among 4 requesters via round-robin arbitration plus a one-entry output buffer.
REQ-014 State: buffer full flag, 32-bit meth/v holding regs, 2-bit priority pointer ptr.
REQ-015 free = !full || indication$heard__RDY (push-through-pop allowed same cycle).
REQ-016 Winner = first i with req$valid[i]=1 searching ptr, ptr+1, ... modulo 4; none if req$valid = 0.
REQ-017 req$heard__RDY[i] = free && winner exists && winner == i; all other bits 0; never depends on any req$heard__ENA.
REQ-018 accept = |(req$heard__ENA & req$heard__RDY); ENA on an un-granted bit is ignored, no state change.
REQ-019 On accept: capture winner's meth/v, full <= 1, ptr <= winner+1 (mod 4, wraps 3 -> 0).
REQ-020 indication$heard__ENA = full && indication$heard__RDY; meth/v outputs driven from holding regs whenever full.
REQ-021 pop = full && indication$heard__RDY; pop without accept -> full <= 0; pop with accept -> full stays 1, new data loaded.
REQ-022 Latency: accepted message appears on downstream exactly 1 cycle after accept; throughput 1 message/cycle while downstream RDY held 1.
REQ-023 Downstream RDY = 0 while full: holding regs and ptr frozen, all req$heard__RDY = 0.
REQ-024 req$valid dropping before accept: grant moves to next valid requester in the same cycle (combinational), ptr unchanged.
REQ-025 Fairness: with all 4 valid and downstream always ready, grants cycle 0,1,2,3,0,... when starting at ptr=0.

Reset
REQ-026 nRST=1 asynchronously clears full=0, ptr=0, meth/v regs=0, grant counters=0.
REQ-027 During reset: indication$heard__ENA=0, indication$meth=0, indication$v=0, req$heard__RDY=0.
REQ-028 Reset mid-transfer discards buffered message; no downstream ENA for it after release.
REQ-029 First accept possible on the first rising edge after nRST deasserts.

Configuration
REQ-030 Macro L_CLASS_OC_HEARD_ARB_STATS_EN defined: grant_count port present; counter i increments by 1 on each accept by requester i, saturates at 16'hFFFF, no wrap.
REQ-031 Macro undefined: grant_count port and counters absent; all other behaviour identical.

Verification
REQ-032 Reset then req$valid=4'b0010, ENA[1], meth=5, v=7, downstream RDY=1 -> RDY=4'b0010, next cycle indication ENA=1, meth=5, v=7, ptr=2.
REQ-033 All valid, continuous ENA on grant, downstream RDY=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one downstream ENA per cycle, data matches source.
REQ-034 Buffer full, downstream RDY=0 for 5 cycles, req$valid=4'b1111 -> req$heard__RDY=0 throughout, outputs stable; RDY=1 -> message popped, next grant issued same cycle.
REQ-035 Assert nRST while full holding meth=9 -> outputs 0 immediately, no ENA with meth=9 after release, ptr=0.
REQ-036 With STATS_EN, 70000 accepts from requester 2 -> grant_count[47:32]=16'hFFFF, other counters 0.
